estagio_busca: RTL

ESTAGIO_BUSCA -- requirements
Module: estagio_busca

---
 rtl/pacote_mips.sv | 15 +
 rtl/registrador_if_id.sv | 64 ++++++
 rtl/estagio_busca.sv | 111 +++++++++++
 3 files changed

// File: rtl/pacote_mips.sv
// Shared definitions for the fetch stage: word width, NOP encoding and
// the fetch FSM state encoding.
package pacote_mips;

  localparam int LARGURA_PALAVRA = 32;

  localparam logic [LARGURA_PALAVRA-1:0] NOP = 32'h0;

  typedef logic [1:0] estado_t;

  localparam estado_t BUSCA  = 2'd0;
  localparam estado_t PARADO = 2'd1;
  localparam estado_t DESVIO = 2'd2;

endpackage

// File: rtl/registrador_if_id.sv
// IF/ID pipeline register. Flush wins over hold, hold wins over load;
// with no control asserted the contents are kept.
import pacote_mips::*;

module registrador_if_id (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       carregar,
  input  logic                       limpar,
  input  logic                       manter,
  input  logic [LARGURA_PALAVRA-1:0] instr_in,
  input  logic [LARGURA_PALAVRA-1:0] pc_in,
  input  logic [LARGURA_PALAVRA-1:0] pc_mais1_in,
  output logic [LARGURA_PALAVRA-1:0] instrucao_id,
  output logic [LARGURA_PALAVRA-1:0] pc_id,
  output logic [LARGURA_PALAVRA-1:0] pc_mais1_id,
  output logic                       valido_id
);

  logic [LARGURA_PALAVRA-1:0] instr_d, instr_q;
  logic [LARGURA_PALAVRA-1:0] pc_d, pc_q;
  logic [LARGURA_PALAVRA-1:0] pc_mais1_d, pc_mais1_q;
  logic                       valido_d, valido_q;

  // Next contents: a flush inserts a bubble but leaves the PC fields alone.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_mais1_d = pc_mais1_q;
    valido_d   = valido_q;
    if (limpar) begin
      instr_d  = NOP;
      valido_d = 1'b0;
    end else if (manter) begin
      instr_d  = instr_q;
    end else if (carregar) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_mais1_d = pc_mais1_in;
      valido_d   = 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_mais1_q <= '0;
      valido_q   <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_mais1_q <= pc_mais1_d;
      valido_q   <= valido_d;
    end
  end

  assign instrucao_id = instr_q;
  assign pc_id        = pc_q;
  assign pc_mais1_id  = pc_mais1_q;
  assign valido_id    = valido_q;

endmodule

// File: rtl/estagio_busca.sv
// Instruction fetch stage: word-addressed PC, redirect/stall FSM and the
// IF/ID register. Optional instruction counter enabled by CONTADOR_INSTR_EN.
//
// state  | meaning
// BUSCA  | normal sequential fetch
// PARADO | stalled, PC and IF/ID held
// DESVIO | first cycle after a redirect, IF/ID holds a bubble
import pacote_mips::*;

module estagio_busca #(
  parameter int PROFUNDIDADE = 32,
  parameter int PC_INICIAL   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       parar,
  input  logic                       desvio_valido,
  input  logic [LARGURA_PALAVRA-1:0] end_desvio,
  output logic [LARGURA_PALAVRA-1:0] endSaida,
  input  logic [LARGURA_PALAVRA-1:0] instrucao,
  output logic [LARGURA_PALAVRA-1:0] instrucao_id,
  output logic [LARGURA_PALAVRA-1:0] pc_id,
  output logic [LARGURA_PALAVRA-1:0] pc_mais1_id,
  output logic                       valido_id
`ifdef CONTADOR_INSTR_EN
  ,output logic [LARGURA_PALAVRA-1:0] contador_instr
`endif
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW-1:0] PC_RESET = AW'(PC_INICIAL);

  logic [AW-1:0] pc_d, pc_q;
  logic [AW-1:0] pc_mais1;
  estado_t       estado_d, estado_q;
  estado_t       estado_alvo;
  logic          carregar;
  logic          sinal_unused;

  // Upper target bits are discarded: the PC wraps at the memory depth.
  assign sinal_unused = ^end_desvio[LARGURA_PALAVRA-1:AW];

  assign pc_mais1 = pc_q + AW'(1);
  assign carregar = !desvio_valido && !parar;

  // Next PC and state; DESVIO does not delay the decision, it only marks it.
  always_comb begin
    pc_d        = pc_q;
    estado_alvo = BUSCA;
    if (desvio_valido) begin
      pc_d        = end_desvio[AW-1:0];
      estado_alvo = DESVIO;
    end else if (parar) begin
      estado_alvo = PARADO;
    end else begin
      pc_d        = pc_mais1;
      estado_alvo = BUSCA;
    end
    case (estado_q)
      BUSCA, PARADO, DESVIO: estado_d = estado_alvo;
      default:               estado_d = BUSCA;
    endcase
  end

  // PC and state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q     <= PC_RESET;
      estado_q <= BUSCA;
    end else begin
      pc_q     <= pc_d;
      estado_q <= estado_d;
    end
  end

  assign endSaida = LARGURA_PALAVRA'(pc_q);

  registrador_if_id u_if_id (
    .clock        (clock),
    .reset        (reset),
    .carregar     (carregar),
    .limpar       (desvio_valido),
    .manter       (parar),
    .instr_in     (instrucao),
    .pc_in        (LARGURA_PALAVRA'(pc_q)),
    .pc_mais1_in  (LARGURA_PALAVRA'(pc_mais1)),
    .instrucao_id (instrucao_id),
    .pc_id        (pc_id),
    .pc_mais1_id  (pc_mais1_id),
    .valido_id    (valido_id)
  );

`ifdef CONTADOR_INSTR_EN
  logic [LARGURA_PALAVRA-1:0] contador_d, contador_q;

  // Counts every edge that writes a real instruction into IF/ID.
  always_comb begin
    contador_d = contador_q;
    if (carregar) contador_d = contador_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!reset) contador_q <= '0;
    else        contador_q <= contador_d;
  end

  assign contador_instr = contador_q;
`endif

endmodule
